// File: rtl/alu_inverse_unit_pkg.sv
// Shared definitions for the ALU inverse unit: data width, forward-ALU op codes, core mode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_inverse_unit_pkg;

  localparam int DATA_W = 8;

  // Op encoding shared with the forward ALU
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic {
    MODE_DIV = 1'b0,
    MODE_MUL = 1'b1
  } core_mode_t;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_inverse_unit_if.sv
// Request/response bundle between a requester and the ALU inverse unit.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response side.
interface alu_inverse_unit_if #(
  parameter int W = alu_inverse_unit_pkg::DATA_W
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   sel;
  logic [W-1:0] res;
  logic [W-1:0] b;
  logic [W-1:0] anc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_rec;
  logic         err;

  modport master (
    output in_valid, sel, res, b, anc, out_ready,
    input  in_ready, out_valid, a_rec, err
  );

  modport slave (
    input  in_valid, sel, res, b, anc, out_ready,
    output in_ready, out_valid, a_rec, err
  );
endinterface

// File: rtl/alu_inv_iter_core.sv
// Iterative datapath: 2W-step restoring divide of {hi,lo}/dsr, or W-step shift-add lo*dsr+hi.
// Latency: done asserts 2W (divide) or W (multiply) cycles after start; results hold until next start.
// Backpressure: none; start is only issued by the owner while the core is idle.
module alu_inv_iter_core
  import alu_inverse_unit_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  core_mode_t   mode,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] dsr,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic         rem_nz,
  output logic         ovf
);

  localparam int CW = $clog2(2*W+1);

  core_mode_t     mode_q;
  logic           busy_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  limit;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [W-1:0]   aux_q;
  logic [W-1:0]   aux_d;
  logic [W-1:0]   dsr_q;
  logic [W-1:0]   hi_q;
  logic [W:0]     shifted;
  logic           ge;
  logic [W:0]     upper;
  logic [2*W:0]   sum;

  assign limit = (mode_q == MODE_DIV) ? CW'(2*W) : CW'(W);
  assign busy  = busy_q;
  assign done  = busy_q && (cnt_q == limit);

  // Divide: aux is the partial remainder, quotient bits shift into acc from the bottom.
  // Multiply: acc low half holds the multiplier, partial product grows in the high half.
  always_comb begin
    shifted = {aux_q, acc_q[2*W-1]};
    ge      = shifted >= {1'b0, dsr_q};
    upper   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dsr_q} : {(W+1){1'b0}});
    acc_d   = acc_q;
    aux_d   = aux_q;
    if (mode_q == MODE_DIV) begin
      acc_d = {acc_q[2*W-2:0], ge};
      aux_d = ge ? (shifted[W-1:0] - dsr_q) : shifted[W-1:0];
    end else begin
      acc_d = {upper, acc_q[W-1:1]};
    end
  end

  assign sum = {1'b0, acc_q} + {{(W+1){1'b0}}, hi_q};

  always_comb begin
    if (mode_q == MODE_DIV) begin
      q      = acc_q[W-1:0];
      rem_nz = |aux_q;
      ovf    = |acc_q[2*W-1:W];
    end else begin
      q      = sum[W-1:0];
      rem_nz = 1'b0;
      ovf    = |sum[2*W:W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_DIV;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      aux_q  <= '0;
      dsr_q  <= '0;
      hi_q   <= '0;
    end else if (start) begin
      mode_q <= mode;
      busy_q <= 1'b1;
      cnt_q  <= '0;
      aux_q  <= '0;
      dsr_q  <= dsr;
      hi_q   <= hi;
      acc_q  <= (mode == MODE_DIV) ? {hi, lo} : {{W{1'b0}}, lo};
    end else if (busy_q) begin
      if (done) begin
        busy_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        aux_q <= aux_d;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_inverse_unit.sv
// Reconstructs forward-ALU operand a from result, b, op select and the ancilla word.
// Latency: simple ops 1 cycle after accept, div-inverse W+1, mul-inverse 2W+1.
// Backpressure: one request in flight; result held until out_ready, in_ready low until then.
module alu_inverse_unit
  import alu_inverse_unit_pkg::*;
#(
  parameter int W = DATA_W
) (
  input logic                clk,
  input logic                rst,
  alu_inverse_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic         accept;
  logic [2:0]   sel_q;
  logic [W-1:0] res_q;
  logic [W-1:0] b_q;
  logic [W-1:0] anc_q;
  logic [W-1:0] a_rec_q;
  logic         err_q;
  logic [W-1:0] a_calc;
  logic         err_calc;
  logic         core_busy;
  logic         core_done;
  logic [W-1:0] core_q;
  logic         core_rem_nz;
  logic         core_ovf;

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Simple ops also spend one cycle in ITER so every result is built from registered inputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ITER;
      ST_ITER: if (!is_iter_op(sel_q) || core_done) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) & ~core_busy & ~rst;
    bus.out_valid = (state_q == ST_DONE);
    bus.a_rec     = a_rec_q;
    bus.err       = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= OP_ADD;
      res_q <= '0;
      b_q   <= '0;
      anc_q <= '0;
    end else if (accept) begin
      sel_q <= bus.sel;
      res_q <= bus.res;
      b_q   <= bus.b;
      anc_q <= bus.anc;
    end
  end

  alu_inv_iter_core #(
    .W (W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept & is_iter_op(bus.sel)),
    .mode   ((bus.sel == OP_DIV) ? MODE_MUL : MODE_DIV),
    .hi     (bus.anc),
    .lo     (bus.res),
    .dsr    (bus.b),
    .busy   (core_busy),
    .done   (core_done),
    .q      (core_q),
    .rem_nz (core_rem_nz),
    .ovf    (core_ovf)
  );

  always_comb begin
    a_calc   = '0;
    err_calc = 1'b0;
    case (sel_q)
      OP_ADD: a_calc = res_q - b_q;
      OP_SUB: a_calc = res_q + b_q;
      OP_MUL: begin
        a_calc   = core_q;
        err_calc = (b_q == '0) | core_rem_nz | core_ovf;
      end
      OP_DIV: begin
        // A zero divisor makes the forward ALU pass a through the ancilla untouched
        if (b_q == '0) begin
          a_calc = anc_q;
        end else begin
          a_calc   = core_q;
          err_calc = (anc_q >= b_q) | core_ovf;
        end
      end
      OP_SHL: begin
        a_calc   = {anc_q[0], res_q[W-1:1]};
        err_calc = res_q[0];
      end
      OP_SHR: begin
        a_calc   = {res_q[W-2:0], anc_q[0]};
        err_calc = res_q[W-1];
      end
      OP_NAND: begin
        a_calc   = (~res_q & b_q) | anc_q;
        err_calc = |(anc_q & b_q);
      end
      OP_XOR: a_calc = res_q ^ b_q;
      default: a_calc = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rec_q <= '0;
      err_q   <= 1'b0;
    end else if ((state_q == ST_ITER) && (state_d == ST_DONE)) begin
      a_rec_q <= a_calc;
      err_q   <= err_calc;
    end
  end

endmodule
